// File: rtl/a_alu_iterativa.sv
// a_alu_iterativa: execution-stage ALU with single-cycle logic/add/sub/SLT
// and 32-iteration shift-add MUL and signed restoring DIV.
// Optional build macro: ALU_FAST_MUL_EN (MUL becomes single-cycle combinational).
module a_alu_iterativa (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  operacion,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] resultado,
    output logic        cero,
    output logic        busy,
    output logic        done,
    output logic        invalida,
    output logic        div_cero
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg;
    // acc: running product (MUL) or partial remainder (DIV)
    // ra:  shifting multiplicand (MUL) or dividend/quotient register (DIV)
    // rb:  shifting multiplier (MUL) or divisor magnitude (DIV)
    logic [31:0] acc, ra, rb;

    logic [31:0] quick;
    logic        quick_inv;
    logic [31:0] mag_a, mag_b;
    logic [31:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [31:0] rem_next, q_next, div_quot, fin;

    // Single-cycle result selection and invalid-code detection
    always_comb begin
        quick     = '0;
        quick_inv = 1'b0;
        case (operacion)
            OP_ADD: quick = op_a + op_b;
            OP_SUB: quick = op_a - op_b;
            OP_AND: quick = op_a & op_b;
            OP_OR:  quick = op_a | op_b;
            OP_XOR: quick = op_a ^ op_b;
            OP_NOR: quick = ~(op_a | op_b);
            OP_SLT: quick = {31'd0, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_FAST_MUL_EN
            OP_MUL: quick = op_a * op_b;
`else
            OP_MUL: quick = '0;
`endif
            OP_DIV: quick = '0;
            default: quick_inv = 1'b1;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide
    always_comb begin
        mag_a     = op_a[31] ? (~op_a + 32'd1) : op_a;
        mag_b     = op_b[31] ? (~op_b + 32'd1) : op_b;
        mul_sum   = acc + (rb[0] ? ra : '0);
        div_shift = {acc, ra[31]};
        div_diff  = div_shift - {1'b0, rb};
        div_ge    = ~div_diff[32];
        rem_next  = div_ge ? div_diff[31:0] : div_shift[31:0];
        q_next    = {ra[30:0], div_ge};
        div_quot  = neg ? (~q_next + 32'd1) : q_next;
        fin       = is_div ? div_quot : mul_sum;
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            neg       <= 1'b0;
            acc       <= '0;
            ra        <= '0;
            rb        <= '0;
            resultado <= '0;
            cero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            invalida  <= 1'b0;
            div_cero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        invalida <= 1'b0;
                        div_cero <= 1'b0;
                        case (operacion)
                            OP_DIV: begin
                                if (op_b == '0) begin
                                    resultado <= '1;
                                    cero      <= 1'b0;
                                    div_cero  <= 1'b1;
                                    done      <= 1'b1;
                                end else begin
                                    state  <= RUN;
                                    busy   <= 1'b1;
                                    cnt    <= '0;
                                    is_div <= 1'b1;
                                    neg    <= op_a[31] ^ op_b[31];
                                    acc    <= '0;
                                    ra     <= mag_a;
                                    rb     <= mag_b;
                                end
                            end
`ifndef ALU_FAST_MUL_EN
                            OP_MUL: begin
                                state  <= RUN;
                                busy   <= 1'b1;
                                cnt    <= '0;
                                is_div <= 1'b0;
                                neg    <= 1'b0;
                                acc    <= '0;
                                ra     <= op_a;
                                rb     <= op_b;
                            end
`endif
                            default: begin
                                resultado <= quick;
                                cero      <= (quick == '0);
                                invalida  <= quick_inv;
                                done      <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc <= rem_next;
                        ra  <= q_next;
                    end else begin
                        acc <= mul_sum;
                        ra  <= {ra[30:0], 1'b0};
                        rb  <= {1'b0, rb[31:1]};
                    end
                    if (cnt == 5'd31) begin
                        resultado <= fin;
                        cero      <= (fin == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a_alu_iterativa.sv
// tb_a_alu_iterativa: directed-vector bench for a_alu_iterativa.
// Honours ALU_FAST_MUL_EN for the expected MUL latency.
module tb_a_alu_iterativa;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  operacion;
    logic [31:0] op_a, op_b;
    logic [31:0] resultado;
    logic        cero, busy, done, invalida, div_cero;

    int n_chk = 0;
    int n_err = 0;

`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    a_alu_iterativa dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operacion (operacion),
        .op_a      (op_a),
        .op_b      (op_b),
        .resultado (resultado),
        .cero      (cero),
        .busy      (busy),
        .done      (done),
        .invalida  (invalida),
        .div_cero  (div_cero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one start, scramble operands after acceptance, wait for done.
    // lat counts edges from the accepting edge (1 = same-edge completion).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_after);
        @(negedge clk);
        operacion = op; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; operacion = 4'b0000;
        busy_after = busy;
        lat = 1;
        while (!done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // done must drop after one cycle while resultado holds
    task automatic chk_pulse(input string tag, input logic [31:0] exp_res);
        @(posedge clk); #1;
        chk({tag, "_done_low"}, done, 1'b0);
        chk({tag, "_hold"}, resultado, exp_res);
    endtask

    initial begin
        int lat;
        logic bz;
        int dones;

        rst_n = 1'b0; start = 1'b0; operacion = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", resultado, 32'd0);
        chk("rst_flags", {cero, busy, done, invalida, div_cero}, 5'b00000);
        @(negedge clk); rst_n = 1'b1;

        // ADD
        run_op(4'b0000, 32'd5, 32'd7, lat, bz);
        chk("add_lat", lat, 1);
        chk("add_res", resultado, 32'd12);
        chk("add_cero_busy", {cero, busy}, 2'b00);
        chk_pulse("add", 32'd12);

        // SLT signed
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, lat, bz);
        chk("slt_res", resultado, 32'd1);
        run_op(4'b1000, 32'd1, 32'hFFFF_FFFF, lat, bz);
        chk("slt_res2", resultado, 32'd0);

        // SUB to zero
        run_op(4'b0001, 32'd9, 32'd9, lat, bz);
        chk("sub_res", resultado, 32'd0);
        chk("sub_cero", cero, 1'b1);

        // Bitwise
        run_op(4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bz);
        chk("and_res", resultado, 32'h00F0_000F);
        run_op(4'b0101, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bz);
        chk("or_res", resultado, 32'hFFF0_0FFF);
        run_op(4'b0110, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bz);
        chk("xor_res", resultado, 32'hFF00_0FF0);
        run_op(4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bz);
        chk("nor_res", resultado, 32'h000F_F000);

        // MUL, with a start poked mid-run that must be ignored
`ifndef ALU_FAST_MUL_EN
        @(negedge clk);
        operacion = 4'b0010; op_a = 32'h0001_0003; op_b = 32'h0002_0005; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mul_busy", busy, 1'b1);
        lat = 1;
        dones = 0;
        while (!done && lat < 50) begin
            if (lat == 6) begin
                @(negedge clk);
                operacion = 4'b0000; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            lat++;
            if (!done) chk("mul_busy_run", busy, 1'b1);
        end
        chk("mul_lat", lat, MUL_LAT);
        chk("mul_res", resultado, 32'h000B_000F);
        chk("mul_busy_end", busy, 1'b0);
        chk_pulse("mul", 32'h000B_000F);
`else
        run_op(4'b0010, 32'h0001_0003, 32'h0002_0005, lat, bz);
        chk("mul_lat", lat, MUL_LAT);
        chk("mul_busy", bz, 1'b0);
        chk("mul_res", resultado, 32'h000B_000F);
        chk_pulse("mul", 32'h000B_000F);
`endif
        run_op(4'b0010, 32'hFFFF_FFFD, 32'd7, lat, bz);
        chk("mul_neg_res", resultado, 32'hFFFF_FFEB);
        chk("mul_neg_lat", lat, MUL_LAT);

        // DIV
        run_op(4'b0011, 32'hFFFF_FFF9, 32'd2, lat, bz);
        chk("div_busy", bz, 1'b1);
        chk("div_lat", lat, DIV_LAT);
        chk("div_res", resultado, 32'hFFFF_FFFD);
        chk_pulse("div", 32'hFFFF_FFFD);
        run_op(4'b0011, 32'd100, 32'd0, lat, bz);
        chk("div0_lat", lat, 1);
        chk("div0_res", resultado, 32'hFFFF_FFFF);
        chk("div0_flag", div_cero, 1'b1);
        run_op(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, lat, bz);
        chk("divwrap_res", resultado, 32'h8000_0000);
        chk("divwrap_flag", div_cero, 1'b0);
        run_op(4'b0011, 32'd100, 32'hFFFF_FFF9, lat, bz);
        chk("divsgn_res", resultado, 32'hFFFF_FFF2);

        // Invalid codes
        run_op(4'b1010, 32'd3, 32'd4, lat, bz);
        chk("inv_lat", lat, 1);
        chk("inv_res", resultado, 32'd0);
        chk("inv_flags", {cero, invalida}, 2'b11);
        run_op(4'b0000, 32'd1, 32'd2, lat, bz);
        chk("inv_clr_res", resultado, 32'd3);
        chk("inv_clr", invalida, 1'b0);
        run_op(4'b1111, 32'd1, 32'd2, lat, bz);
        chk("none_inv", {resultado, invalida}, {32'd0, 1'b1});

        // Reset at iteration 10 of a DIV
        @(negedge clk);
        operacion = 4'b0011; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_res", resultado, 32'd0);
        chk("rst_mid_flags", {cero, busy, done, invalida, div_cero}, 5'b00000);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("rst_mid_nodone", dones, 0);
        run_op(4'b0000, 32'd2, 32'd2, lat, bz);
        chk("post_rst_add", resultado, 32'd4);
        chk("post_rst_lat", lat, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/a_alu_iterativa.md
# a_alu_iterativa

Execution-stage ALU that consumes the 4-bit `operacion` code from the ALU control stage together with two 32-bit operands and produces a 32-bit result. Logic, add/sub and SLT complete in one cycle. MUL (shift-add) and DIV (signed restoring) are iterative over 32 cycles. A start/busy/done handshake lets the control path stall while a long operation runs.

## Interface
- No parameters; datapath fixed at 32 bits, operation code at 4 bits.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `operacion` in 4: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1000 SLT, 1111 none; any other code is invalid.
- `op_a` in 32: operand A (rs).
- `op_b` in 32: operand B (rt/imm).
- `resultado` out 32: registered result, held until the next accepted start.
- `cero` out 1: `resultado`==0, registered with `resultado`.
- `busy` out 1: iterative operation in progress.
- `done` out 1: one-cycle pulse when `resultado` is updated.
- `invalida` out 1: last accepted code was 1111 or undefined.
- `div_cero` out 1: last accepted DIV had `op_b`==0.

## Operation
- States: IDLE and RUN. Reset enters IDLE; all outputs are 0.
- IDLE with `start`=1: `operacion`, `op_a` and `op_b` are latched, then:
  - Single-cycle ops: result written and `done`=1 on the same edge; stay in IDLE.
  - ADD/SUB: modulo 2^32, no overflow trap.
  - SLT: signed compare, result 32'd1 or 32'd0.
  - AND/OR/XOR/NOR: bitwise.
  - Invalid code or 1111: `resultado`=0, `cero`=1, `invalida`=1, `done`=1.
  - DIV with `op_b`==0: `resultado`=32'hFFFFFFFF, `div_cero`=1, `done`=1; no RUN.
  - MUL, or DIV with `op_b`≠0: enter RUN, `busy`=1, 5-bit iteration counter cleared.
- RUN: one iteration per cycle; counter increments 0..31.
  - MUL: shift-add over the 32 bits of `op_b`, keeping the low 32 bits of the product. The result is identical for signed and unsigned operands.
  - DIV: restoring division on the operand magnitudes. On the final iteration the quotient is negated if the operand signs differ, giving truncation toward zero. Remainder is discarded.
  - 32'h80000000 / 32'hFFFFFFFF yields 32'h80000000 (wrap).
  - Counter==31 edge: write `resultado`/`cero`, pulse `done`, clear `busy`, return to IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- `invalida` and `div_cero` update on every accepted start: they are set or cleared per operation and then held.
- Reset mid-RUN: abort immediately and return to reset values; no `done` pulse.

## Timing
- `start` sampled at edge N, single-cycle op: `resultado`/`done` valid after edge N; latency 1.
- `start` at N, MUL/DIV: `busy`=1 after N. Iterations run on edges N+1..N+32. `done`=1 and `busy`=0 after N+32.
- `done` is high for exactly one cycle. `resultado` is stable from that edge until the next accepted start.
- In the `done` cycle `busy`=0, so a `start` at the next edge is accepted (back-to-back).
- Operands may change after the accepting edge without affecting the result.

## Configuration
- `ALU_FAST_MUL_EN` defined: MUL uses a single-cycle combinational multiply. It completes like ADD (latency 1, never asserts `busy`). DIV remains iterative.
- Undefined: MUL uses the 32-iteration path described above.

## Test plan
- Reset, then ADD 5+7 with `start` -> after 1 edge `resultado`=12, `cero`=0, `done` pulses once, `busy`=0.
- SLT `op_a`=32'hFFFFFFFF, `op_b`=1 -> `resultado`=1. Then SUB 9-9 -> `resultado`=0, `cero`=1.
- MUL 32'h00010003 × 32'h00020005 -> `busy` high 32 cycles, then `resultado`=32'h000B000F and `done`. A `start` asserted mid-run is ignored. With `ALU_FAST_MUL_EN`, the same result arrives after 1 edge.
- DIV -7 / 2 -> `resultado`=32'hFFFFFFFD after 32 cycles. DIV 100 / 0 -> `resultado`=32'hFFFFFFFF, `div_cero`=1, latency 1.
- `operacion`=4'b1010 -> `invalida`=1, `resultado`=0. A following valid ADD clears `invalida`.
- Assert `rst_n`=0 at iteration 10 of a DIV -> all outputs 0 immediately, no `done`. The next ADD works normally.
